// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit (mdu_hilo).
// Optional feature macro: MDU_MULT_REG_EN adds the registered-multiply state MUL_RUN.
// The ALU_* codes normally come from the ALU defines header; the block below only
// supplies them when that header has not been seen in this compilation unit.
`ifndef ALU_MULT
`define ALU_MULT  5'd10
`define ALU_MULTU 5'd11
`define ALU_DIV   5'd12
`define ALU_DIVU  5'd13
`define ALU_MTHI  5'd14
`define ALU_MTLO  5'd15
`define ALU_MFHI  5'd16
`define ALU_MFLO  5'd17
`endif

package mdu_pkg;
    localparam int MDU_DIV_CYCLES = 32;
    localparam int MDU_DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIV_RUN = 3'd1,
        ST_DONE    = 3'd2,
        ST_HOLD    = 3'd3
`ifdef MDU_MULT_REG_EN
        , ST_MUL_RUN = 3'd4
`endif
    } mdu_state_e;
endpackage

// File: rtl/mdu_hilo_div.sv
// div_radix2: unsigned restoring divider, one quotient bit per cycle.
// start_i loads the operands and clears the counter/remainder; last_o marks the
// cycle performing the final step. Results stay on quot_o/rem_o until the next start.
module div_radix2
    import mdu_pkg::*;
#(
    parameter int W = MDU_DIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         kill_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         last_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);
    localparam int CW = $clog2(W);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;

    // One restoring step: shift in the next dividend bit, subtract when no borrow.
    // The quotient register doubles as the dividend shifter.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        run_d  = run_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (kill_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (run_q) begin
            if (diff[W]) begin
                rem_d = rem_sh[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end else begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) begin
                run_d = 1'b0;
            end
        end
    end

    // Divider state registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign last_o = run_q && (cnt_q == CW'(W-1));
    assign quot_o = quo_q;
    assign rem_o  = rem_q;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: EX-stage multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO; divides stall the pipeline
// while the radix-2 divider iterates. Sign correction of divide results is done here.
// Optional feature macro: MDU_MULT_REG_EN makes multiply a registered two-cycle op.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [4:0]  alucontrol_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    mdu_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic        sgn_q, sgn_d;
    logic        bzero_q, bzero_d;
    logic        div_start;
    logic        div_last;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        op_sgn;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [31:0] q_fix, r_fix;
`ifdef MDU_MULT_REG_EN
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_sgn_q, mul_sgn_d;
`endif

    // Full 64-bit product; sign-extending both operands gives the signed result.
    function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return ax * bx;
    endfunction

    // Two's-complement negate when requested.
    function automatic logic [31:0] cneg(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    div_radix2 #(.W(DIV_CYCLES)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .kill_i     (flush_i),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .last_o     (div_last),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Operand magnitudes for DIV and sign-corrected divide results.
    // Divide by zero forces an all-ones quotient; the remainder already equals a.
    always_comb begin
        op_sgn = (alucontrol_i == `ALU_DIV);
        a_neg  = op_sgn & a_i[31];
        b_neg  = op_sgn & b_i[31];
        abs_a  = cneg(a_neg, a_i);
        abs_b  = cneg(b_neg, b_i);
        q_fix  = bzero_q ? 32'hFFFF_FFFF : cneg(sgn_q & (a_neg_q ^ b_neg_q), div_quot);
        r_fix  = cneg(sgn_q & a_neg_q, div_rem);
    end

    // FSM next state, HI/LO next values and the stall request.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        sgn_d     = sgn_q;
        bzero_d   = bzero_q;
        div_start = 1'b0;
        stall_o   = 1'b0;
`ifdef MDU_MULT_REG_EN
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_sgn_d = mul_sgn_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    case (alucontrol_i)
                        `ALU_DIV, `ALU_DIVU: begin
                            div_start = 1'b1;
                            stall_o   = 1'b1;
                            a_neg_d   = a_neg;
                            b_neg_d   = b_neg;
                            sgn_d     = op_sgn;
                            bzero_d   = (b_i == 32'd0);
                            state_d   = ST_DIV_RUN;
                        end
                        `ALU_MTHI: hi_d = a_i;
                        `ALU_MTLO: lo_d = a_i;
                        `ALU_MULT, `ALU_MULTU: begin
`ifdef MDU_MULT_REG_EN
                            stall_o   = 1'b1;
                            mul_a_d   = a_i;
                            mul_b_d   = b_i;
                            mul_sgn_d = (alucontrol_i == `ALU_MULT);
                            state_d   = ST_MUL_RUN;
`else
                            {hi_d, lo_d} = mul64(alucontrol_i == `ALU_MULT, a_i, b_i);
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (div_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = r_fix;
                    lo_d    = q_fix;
                    state_d = stall_i ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush_i || !stall_i) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MDU_MULT_REG_EN
            ST_MUL_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    {hi_d, lo_d} = mul64(mul_sgn_q, mul_a_q, mul_b_q);
                    state_d      = stall_i ? ST_HOLD : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            stall_o = 1'b0;
        end
    end

    // State, HI/LO and latched divide/multiply context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            sgn_q     <= 1'b0;
            bzero_q   <= 1'b0;
`ifdef MDU_MULT_REG_EN
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sgn_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            sgn_q     <= sgn_d;
            bzero_q   <= bzero_d;
`ifdef MDU_MULT_REG_EN
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_sgn_q <= mul_sgn_d;
`endif
        end
    end

    // Register read port: no bypass, reads the committed HI/LO.
    always_comb begin
        rdata_o = 32'd0;
        if (!rst) begin
            if (alucontrol_i == `ALU_MFHI) begin
                rdata_o = hi_q;
            end else if (alucontrol_i == `ALU_MFLO) begin
                rdata_o = lo_q;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule
